// File: rtl/fp16_pkg.sv
// Shared binary16 constants and the unpacked-operand type for the fp16 adder.
package fp16_pkg;
    localparam int EXP_WIDTH = 5;
    localparam int MAN_WIDTH = 10;
    localparam int BIAS      = 15;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] NEG_INF = 16'hFC00;

    // man carries the hidden bit in its MSB
    typedef struct packed {
        logic        sign;
        logic [4:0]  exp;
        logic [10:0] man;
    } fp16_unpacked_t;
endpackage

// File: rtl/fp16_lzc.sv
// 14-bit leading-zero counter; an all-zero input reports 14.
module fp16_lzc (
    input  logic [13:0] din,
    output logic [3:0]  cnt
);
    always_comb begin
        cnt = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (din[i]) cnt = 4'(13 - i);
        end
    end
endmodule

// File: rtl/fp16_adder.sv
// Single-stage IEEE-754 binary16 adder, round-to-nearest-even.
// Define FP16_ADD_DENORM_EN for subnormal support; otherwise flush-to-zero.
module fp16_adder
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_WIDTH  = 5,
    parameter int MAN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_a_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_a_tdata,
    input  logic                  s_axis_b_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_b_tdata,
    output logic                  m_axis_result_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_result_tdata
);
    function automatic fp16_unpacked_t unpack(input logic [15:0] x);
        fp16_unpacked_t u;
        u.sign = x[15];
        if (x[14:10] == 5'd0) begin
            u.exp = 5'd1;
`ifdef FP16_ADD_DENORM_EN
            u.man = {1'b0, x[9:0]};
`else
            u.man = 11'd0;
`endif
        end else begin
            u.exp = x[14:10];
            u.man = {1'b1, x[9:0]};
        end
        return u;
    endfunction

    logic                 fire;
    logic [EXP_WIDTH-1:0] a_exp, b_exp;
    logic [MAN_WIDTH-1:0] a_frac, b_frac;
    logic                 nan_a, nan_b, inf_a, inf_b;
    fp16_unpacked_t       ua, ub, ul, us;
    logic                 swap;
    logic [4:0]           d;
    logic [27:0]          align_tmp;
    logic [13:0]          large_al, small_al;
    logic [14:0]          sum;
    logic [3:0]           lz, sh;
    logic [13:0]          norm;
    logic [6:0]           exp_n, exp_r;
    logic                 round_up;
    logic [11:0]          man_r;
    logic [9:0]           frac;
    logic                 hidden, overflow, underflow;
    logic [15:0]          res;

    assign fire   = s_axis_a_tvalid & s_axis_b_tvalid;
    assign a_exp  = s_axis_a_tdata[DATA_WIDTH-2 -: EXP_WIDTH];
    assign b_exp  = s_axis_b_tdata[DATA_WIDTH-2 -: EXP_WIDTH];
    assign a_frac = s_axis_a_tdata[MAN_WIDTH-1:0];
    assign b_frac = s_axis_b_tdata[MAN_WIDTH-1:0];
    assign nan_a  = (&a_exp) & (|a_frac);
    assign nan_b  = (&b_exp) & (|b_frac);
    assign inf_a  = (&a_exp) & ~(|a_frac);
    assign inf_b  = (&b_exp) & ~(|b_frac);

    assign ua   = unpack(s_axis_a_tdata);
    assign ub   = unpack(s_axis_b_tdata);
    assign swap = {ub.exp, ub.man} > {ua.exp, ua.man};
    assign ul   = swap ? ub : ua;
    assign us   = swap ? ua : ub;
    assign d    = ul.exp - us.exp;

    // Smaller operand right-shifted with everything shifted out folded into sticky
    assign align_tmp = {us.man, 3'b000, 14'd0} >> d;
    assign small_al  = (d >= 5'd14) ? {13'd0, |us.man}
                                    : {align_tmp[27:15], align_tmp[14] | (|align_tmp[13:0])};
    assign large_al  = {ul.man, 3'b000};
    assign sum = (ul.sign ^ us.sign) ? ({1'b0, large_al} - {1'b0, small_al})
                                     : ({1'b0, large_al} + {1'b0, small_al});

    fp16_lzc u_lzc (
        .din (sum[13:0]),
        .cnt (lz)
    );

`ifdef FP16_ADD_DENORM_EN
    logic [4:0] lim;
    assign lim = ul.exp - 5'd1;
    assign sh  = ({1'b0, lz} > lim) ? lim[3:0] : lz;
`else
    assign sh  = lz;
`endif

    always_comb begin
        if (sum[14]) begin
            norm  = {sum[14:2], sum[1] | sum[0]};
            exp_n = {2'b00, ul.exp} + 7'd1;
        end else begin
            norm  = sum[13:0] << sh;
            exp_n = {2'b00, ul.exp} - {3'b000, sh};
        end
    end

    assign round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign man_r     = {1'b0, norm[13:3]} + {11'd0, round_up};
    assign exp_r     = exp_n + {6'd0, man_r[11]};
    assign frac      = man_r[11] ? man_r[10:1] : man_r[9:0];
    assign hidden    = man_r[11] | man_r[10];
    // exp_r is a 7-bit two's-complement value; bit 6 marks a negative exponent
    assign overflow  = ~exp_r[6] & (exp_r >= 7'd31);
    assign underflow = exp_r[6] | (exp_r == 7'd0);

    always_comb begin
        res = {ul.sign, hidden ? exp_r[4:0] : 5'd0, frac};
        if (nan_a | nan_b | (inf_a & inf_b & (s_axis_a_tdata[15] ^ s_axis_b_tdata[15])))
            res = QNAN;
        else if (inf_a)
            res = s_axis_a_tdata;
        else if (inf_b)
            res = s_axis_b_tdata;
        else if (sum == 15'd0)
            res = {ua.sign & ub.sign, 15'd0};
        else if (overflow)
            res = ul.sign ? NEG_INF : POS_INF;
`ifndef FP16_ADD_DENORM_EN
        else if (underflow)
            res = {ul.sign, 15'd0};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= '0;
        end else begin
            m_axis_result_tvalid <= fire;
            if (fire) m_axis_result_tdata <= res;
        end
    end

`ifdef FP16_ADD_DENORM_EN
    logic unused_ok;
    assign unused_ok = underflow;
`endif
endmodule

// File: tb/tb_fp16_adder.sv
// Directed self-checking bench for fp16_adder (both FP16_ADD_DENORM_EN builds).
module tb_fp16_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] a_data = 16'h0, b_data = 16'h0;
    logic        r_valid;
    logic [15:0] r_data;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    fp16_adder dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tdata       (a_data),
        .s_axis_b_tvalid      (b_valid),
        .s_axis_b_tdata       (b_data),
        .m_axis_result_tvalid (r_valid),
        .m_axis_result_tdata  (r_data)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic va, input logic vb, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        a_valid = va; b_valid = vb; a_data = a; b_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total_cnt++;
        if (r_valid !== 1'b0 || r_data !== 16'h0000)
            $display("FAIL reset_init: got v=%b d=%h want v=0 d=0000", r_valid, r_data);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        drive(1'b1, 1'b1, 16'h3C00, 16'h3C00);
        drive(1'b1, 1'b1, 16'h4000, 16'h3C00);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (r_valid !== 1'b0 || r_data !== 16'h0000)
            $display("FAIL reset_mid: got v=%b d=%h want v=0 d=0000", r_valid, r_data);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_basic;
        @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1; a_data = 16'h3C00; b_data = 16'h3C00;
        #1;
        total_cnt++;
        if (r_valid !== 1'b0)
            $display("FAIL basic_early: got v=%b want v=0 before edge", r_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (r_valid !== 1'b1 || r_data !== 16'h4000)
            $display("FAIL basic_add: got v=%b d=%h want v=1 d=4000", r_valid, r_data);
        else pass_cnt++;
        drive(1'b0, 1'b0, 16'h1234, 16'h5678);
        total_cnt++;
        if (r_valid !== 1'b0 || r_data !== 16'h4000)
            $display("FAIL basic_idle: got v=%b d=%h want v=0 d=4000", r_valid, r_data);
        else pass_cnt++;
    endtask

    task automatic test_vectors(input string name, input logic [15:0] vec [][3]);
        for (int i = 0; i < vec.size(); i++) begin
            drive(1'b1, 1'b1, vec[i][0], vec[i][1]);
            total_cnt++;
            if (r_valid !== 1'b1 || r_data !== vec[i][2])
                $display("FAIL %s[%0d] %h+%h: got v=%b d=%h want v=1 d=%h",
                         name, i, vec[i][0], vec[i][1], r_valid, r_data, vec[i][2]);
            else pass_cnt++;
        end
    endtask

    task automatic test_arith;
        logic [15:0] cancel [][3];
        logic [15:0] rnd [][3];
        logic [15:0] spec [][3];
        logic [15:0] sub [][3];
        cancel = '{'{16'h3C00, 16'hBC00, 16'h0000}, '{16'h8000, 16'h8000, 16'h8000},
                   '{16'h0000, 16'h8000, 16'h0000}};
        rnd    = '{'{16'h3C00, 16'h1400, 16'h3C01}, '{16'h3C00, 16'h1000, 16'h3C00},
                   '{16'h3C01, 16'h1000, 16'h3C02}};
        spec   = '{'{16'h7BFF, 16'h7BFF, 16'h7C00}, '{16'h7C00, 16'hFC00, 16'h7E00},
                   '{16'h7E01, 16'h3C00, 16'h7E00}, '{16'h7C00, 16'h3C00, 16'h7C00}};
`ifdef FP16_ADD_DENORM_EN
        sub    = '{'{16'h0001, 16'h0001, 16'h0002}, '{16'h03FF, 16'h0001, 16'h0400}};
`else
        sub    = '{'{16'h0001, 16'h0001, 16'h0000}, '{16'h03FF, 16'h0001, 16'h0000}};
`endif
        test_vectors("cancel", cancel);
        test_vectors("round", rnd);
        test_vectors("special", spec);
        test_vectors("subnormal", sub);
    endtask

    task automatic test_valid_gating;
        drive(1'b1, 1'b1, 16'h4200, 16'h3C00);
        total_cnt++;
        if (r_valid !== 1'b1 || r_data !== 16'h4400)
            $display("FAIL gate_setup: got v=%b d=%h want v=1 d=4400", r_valid, r_data);
        else pass_cnt++;
        drive(1'b1, 1'b0, 16'h3C00, 16'h3C00);
        total_cnt++;
        if (r_valid !== 1'b0 || r_data !== 16'h4400)
            $display("FAIL gate_a_only: got v=%b d=%h want v=0 d=4400", r_valid, r_data);
        else pass_cnt++;
        drive(1'b0, 1'b1, 16'h3C00, 16'h4000);
        total_cnt++;
        if (r_valid !== 1'b0 || r_data !== 16'h4400)
            $display("FAIL gate_b_only: got v=%b d=%h want v=0 d=4400", r_valid, r_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] ops [4];
        logic [15:0] exp_res [4];
        ops     = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        exp_res = '{16'h4000, 16'h4200, 16'h4400, 16'h4500};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, ops[i], 16'h3C00);
            total_cnt++;
            if (r_valid !== 1'b1 || r_data !== exp_res[i])
                $display("FAIL b2b[%0d]: got v=%b d=%h want v=1 d=%h", i, r_valid, r_data, exp_res[i]);
            else pass_cnt++;
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        total_cnt++;
        if (r_valid !== 1'b0 || r_data !== 16'h4500)
            $display("FAIL b2b_end: got v=%b d=%h want v=0 d=4500", r_valid, r_data);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_arith;
        test_valid_gating;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
